// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: icache address/data port, redirect input and the
// valid/ready instruction stream toward decode.
interface fetch_unit_if;
    logic [31:0] icache_address;
    logic [31:0] icache_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_fault;

    // Fetch unit side
    modport master (
        output icache_address,
        input  icache_data,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc,
        output instr_fault
    );

    // Environment side (icache, branch unit, decode)
    modport slave (
        input  icache_address,
        output icache_data,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc,
        input  instr_fault
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one icache read per cycle when
// there is room, absorbs the 1-cycle icache latency with an output entry plus
// a skid entry, and flushes everything in flight on a redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h8002_0000,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic          clock,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    localparam logic [31:0] LAST_PC = RESET_PC + 32'(MEM_BYTES) - 32'd4;

    // A PC outside the icache window produces a fault instead of a word.
    function automatic logic outside_window(input logic [31:0] a);
        return (a < RESET_PC) || (a > LAST_PC);
    endfunction

    logic [31:0] r_pc;
    logic        r_resp_valid;
    logic [31:0] r_resp_pc;

    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic [31:0] r_out_pc;
    logic        r_out_fault;

    logic        r_skid_valid;
    logic [31:0] r_skid_data;
    logic [31:0] r_skid_pc;
    logic        r_skid_fault;

    logic        w_pop;
    logic [2:0]  w_occ;
    logic        w_issue;
    logic        w_resp_fault;
    logic [31:0] w_resp_data;

    // Entries still held after this edge (the in-flight response counts,
    // since it lands this edge); a new read is only issued if it will fit.
    assign w_pop        = r_out_valid & bus.instr_ready;
    assign w_occ        = 3'(r_out_valid) + 3'(r_skid_valid) + 3'(r_resp_valid) - 3'(w_pop);
    assign w_issue      = !bus.redirect_valid && (w_occ < 3'd2);
    assign w_resp_fault = outside_window(r_resp_pc);
    assign w_resp_data  = w_resp_fault ? 32'h0 : bus.icache_data;

    assign bus.icache_address = r_pc;
    assign bus.instr_valid    = r_out_valid;
    assign bus.instr_data     = r_out_data;
    assign bus.instr_pc       = r_out_pc;
    assign bus.instr_fault    = r_out_fault;

    // PC and request tracking: advance on issue, jump on redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_resp_valid <= 1'b0;
            r_resp_pc    <= 32'h0;
        end else if (bus.redirect_valid) begin
            r_pc         <= {bus.redirect_pc[31:2], 2'b00};
            r_resp_valid <= 1'b0;
        end else if (w_issue) begin
            r_resp_valid <= 1'b1;
            r_resp_pc    <= r_pc;
            r_pc         <= r_pc + 32'd4;
        end else begin
            r_resp_valid <= 1'b0;
        end
    end

    // Two-entry FIFO: output entry, then skid; the response fills the first free slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= 32'h0;
            r_out_pc     <= 32'h0;
            r_out_fault  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= 32'h0;
            r_skid_pc    <= 32'h0;
            r_skid_fault <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_out_valid && !w_pop) begin
            // Output entry is stalled; only the skid slot can take the response.
            if (!r_skid_valid) begin
                r_skid_valid <= r_resp_valid;
                if (r_resp_valid) begin
                    r_skid_data  <= w_resp_data;
                    r_skid_pc    <= r_resp_pc;
                    r_skid_fault <= w_resp_fault;
                end
            end
        end else if (r_skid_valid) begin
            // Output entry is free: skid moves up, response drops into skid.
            r_out_valid  <= 1'b1;
            r_out_data   <= r_skid_data;
            r_out_pc     <= r_skid_pc;
            r_out_fault  <= r_skid_fault;
            r_skid_valid <= r_resp_valid;
            if (r_resp_valid) begin
                r_skid_data  <= w_resp_data;
                r_skid_pc    <= r_resp_pc;
                r_skid_fault <= w_resp_fault;
            end
        end else begin
            // Both free: the response goes straight to the output entry.
            r_out_valid <= r_resp_valid;
            if (r_resp_valid) begin
                r_out_data  <= w_resp_data;
                r_out_pc    <= r_resp_pc;
                r_out_fault <= w_resp_fault;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an icache model with a fixed registered read latency,
// directed scenarios, and a randomized run checked against an in-order
// instruction-stream model.
module tb_fetch_unit;

    localparam logic [31:0] BASE = 32'h8002_0000;
    localparam int unsigned MEMB = 1024;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(BASE), .MEM_BYTES(MEMB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic in_win(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'(MEMB) - 32'd4);
    endfunction

    // Word k of the preloaded window is 0x1000_0000 + k; outside it returns junk.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a - BASE) >> 2;
        return in_win(a) ? (32'h1000_0000 + idx) : 32'hBAD0_BAD0;
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        return in_win(a) ? mem_word(a) : 32'h0;
    endfunction

    // icache: registered read of whatever address is presented
    always @(posedge clock) bus.icache_data <= mem_word(bus.icache_address);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.instr_valid); end
        n_tests++; if (bus.instr_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.instr_data); end
        n_tests++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", bus.instr_pc); end
        n_tests++; if (bus.instr_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %0b want 0", bus.instr_fault); end
        n_tests++; if (bus.icache_address !== BASE) begin n_fail++; $display("FAIL reset_addr got %h want %h", bus.icache_address, BASE); end
    endtask

    task automatic test_stream();
        logic [31:0] p;
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        tick();
        n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_first_edge_valid got %0b want 0", bus.instr_valid); end
        for (int k = 0; k < 6; k++) begin
            tick();
            p = BASE + 32'(4 * k);
            n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid k=%0d got %0b want 1", k, bus.instr_valid); end
            n_tests++; if (bus.instr_pc !== p) begin n_fail++; $display("FAIL stream_pc k=%0d got %h want %h", k, bus.instr_pc, p); end
            n_tests++; if (bus.instr_data !== 32'h1000_0000 + 32'(k)) begin n_fail++; $display("FAIL stream_data k=%0d got %h want %h", k, bus.instr_data, 32'h1000_0000 + 32'(k)); end
            n_tests++; if (bus.instr_fault !== 1'b0) begin n_fail++; $display("FAIL stream_fault k=%0d got %0b want 0", k, bus.instr_fault); end
        end
    endtask

    // Continues from test_stream, which left 0x80020014 on the output.
    task automatic test_backpressure();
        logic [31:0] held;
        logic [31:0] p;
        held = BASE + 32'h14;
        bus.instr_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid j=%0d got %0b want 1", j, bus.instr_valid); end
            n_tests++; if (bus.instr_pc !== held) begin n_fail++; $display("FAIL stall_pc j=%0d got %h want %h", j, bus.instr_pc, held); end
            n_tests++; if (bus.instr_data !== exp_data(held)) begin n_fail++; $display("FAIL stall_data j=%0d got %h want %h", j, bus.instr_data, exp_data(held)); end
            n_tests++; if (bus.icache_address !== held + 32'd8) begin n_fail++; $display("FAIL stall_addr j=%0d got %h want %h", j, bus.icache_address, held + 32'd8); end
        end
        bus.instr_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick();
            p = held + 32'(4 * j);
            n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL release_valid j=%0d got %0b want 1", j, bus.instr_valid); end
            n_tests++; if (bus.instr_pc !== p) begin n_fail++; $display("FAIL release_pc j=%0d got %h want %h", j, bus.instr_pc, p); end
            n_tests++; if (bus.instr_data !== exp_data(p)) begin n_fail++; $display("FAIL release_data j=%0d got %h want %h", j, bus.instr_data, exp_data(p)); end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] p;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8002_0043;
        tick();
        bus.redirect_valid = 1'b0;
        n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_gap1 got %0b want 0", bus.instr_valid); end
        tick();
        n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_gap2 got %0b want 0", bus.instr_valid); end
        for (int j = 0; j < 3; j++) begin
            tick();
            p = 32'h8002_0040 + 32'(4 * j);
            n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL redir_valid j=%0d got %0b want 1", j, bus.instr_valid); end
            n_tests++; if (bus.instr_pc !== p) begin n_fail++; $display("FAIL redir_pc j=%0d got %h want %h", j, bus.instr_pc, p); end
            n_tests++; if (bus.instr_data !== 32'h1000_0010 + 32'(j)) begin n_fail++; $display("FAIL redir_data j=%0d got %h want %h", j, bus.instr_data, 32'h1000_0010 + 32'(j)); end
        end
    endtask

    task automatic test_fault();
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8002_03FC;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        tick();
        n_tests++; if (bus.instr_pc !== 32'h8002_03FC) begin n_fail++; $display("FAIL edge_pc got %h want 800203fc", bus.instr_pc); end
        n_tests++; if (bus.instr_fault !== 1'b0) begin n_fail++; $display("FAIL edge_fault got %0b want 0", bus.instr_fault); end
        n_tests++; if (bus.instr_data !== 32'h1000_00FF) begin n_fail++; $display("FAIL edge_data got %h want 100000ff", bus.instr_data); end
        tick();
        n_tests++; if (bus.instr_pc !== 32'h8002_0400) begin n_fail++; $display("FAIL past_pc got %h want 80020400", bus.instr_pc); end
        n_tests++; if (bus.instr_fault !== 1'b1) begin n_fail++; $display("FAIL past_fault got %0b want 1", bus.instr_fault); end
        n_tests++; if (bus.instr_data !== 32'h0) begin n_fail++; $display("FAIL past_data got %h want 0", bus.instr_data); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        tick();
        n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid got %0b want 1", bus.instr_valid); end
        n_tests++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL zero_pc got %h want 0", bus.instr_pc); end
        n_tests++; if (bus.instr_fault !== 1'b1) begin n_fail++; $display("FAIL zero_fault got %0b want 1", bus.instr_fault); end
        n_tests++; if (bus.instr_data !== 32'h0) begin n_fail++; $display("FAIL zero_data got %h want 0", bus.instr_data); end
    endtask

    task automatic test_reset_mid_stall();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        tick();
        tick();
        tick();
        bus.instr_ready = 1'b0;
        tick();
        tick();
        tick();
        n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL prestall_valid got %0b want 1", bus.instr_valid); end
        reset = 1'b1;
        tick();
        n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %0b want 0", bus.instr_valid); end
        n_tests++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL midrst_pc got %h want 0", bus.instr_pc); end
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        tick();
        n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL recover_gap got %0b want 0", bus.instr_valid); end
        tick();
        n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL recover_valid got %0b want 1", bus.instr_valid); end
        n_tests++; if (bus.instr_pc !== BASE) begin n_fail++; $display("FAIL recover_pc got %h want %h", bus.instr_pc, BASE); end
        n_tests++; if (bus.instr_data !== 32'h1000_0000) begin n_fail++; $display("FAIL recover_data got %h want 10000000", bus.instr_data); end
    endtask

    task automatic test_redirect_handshake();
        bus.instr_ready = 1'b1;
        tick();
        tick();
        n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL rh_pre_valid got %0b want 1", bus.instr_valid); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8002_0100;
        tick();
        bus.redirect_valid = 1'b0;
        n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rh_gap1 got %0b want 0", bus.instr_valid); end
        tick();
        n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rh_gap2 got %0b want 0", bus.instr_valid); end
        tick();
        n_tests++; if (bus.instr_pc !== 32'h8002_0100) begin n_fail++; $display("FAIL rh_target_pc got %h want 80020100", bus.instr_pc); end
        n_tests++; if (bus.instr_data !== 32'h1000_0040) begin n_fail++; $display("FAIL rh_target_data got %h want 10000040", bus.instr_data); end
        tick();
        n_tests++; if (bus.instr_pc !== 32'h8002_0104) begin n_fail++; $display("FAIL rh_next_pc got %h want 80020104", bus.instr_pc); end
    endtask

    // Random ready/redirect traffic against an in-order stream model: the
    // accepted instructions must be consecutive PCs from the last redirect
    // target, two bubble cycles follow each redirect, and the output never
    // drops out otherwise.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic        hs;
        logic        rv;
        int          since;
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        tick();
        reset = 1'b0;
        exp_pc = BASE;
        since  = 0;
        for (int i = 0; i < 600; i++) begin
            rv  = (i == 0) || ($urandom_range(0, 99) < 6);
            tgt = ($urandom_range(0, 9) == 0) ? $urandom
                                              : BASE + 32'($urandom_range(0, 260) * 4) + 32'($urandom_range(0, 3));
            if (i == 0) tgt = BASE;
            bus.instr_ready    = ($urandom_range(0, 99) < 65);
            bus.redirect_valid = rv;
            bus.redirect_pc    = tgt;
            hs = bus.instr_valid && bus.instr_ready;
            tick();
            bus.redirect_valid = 1'b0;
            if (rv) begin
                exp_pc = {tgt[31:2], 2'b00};
                since  = 1;
                n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_flush i=%0d got %0b want 0", i, bus.instr_valid); end
            end else if (since == 1) begin
                since = 2;
                n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_bubble i=%0d got %0b want 0", i, bus.instr_valid); end
            end else begin
                if (since == 2) since = 0;
                else if (hs) exp_pc = exp_pc + 32'd4;
                n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_valid i=%0d got %0b want 1", i, bus.instr_valid); end
                n_tests++; if (bus.instr_pc !== exp_pc) begin n_fail++; $display("FAIL rnd_pc i=%0d got %h want %h", i, bus.instr_pc, exp_pc); end
                n_tests++; if (bus.instr_data !== exp_data(exp_pc)) begin n_fail++; $display("FAIL rnd_data i=%0d got %h want %h", i, bus.instr_data, exp_data(exp_pc)); end
                n_tests++; if (bus.instr_fault !== !in_win(exp_pc)) begin n_fail++; $display("FAIL rnd_fault i=%0d got %0b want %0b", i, bus.instr_fault, !in_win(exp_pc)); end
            end
        end
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fault();
        test_reset_mid_stall();
        test_redirect_handshake();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
